// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO: pointer width and
// parameter legality used by the top-level elaboration checks.
package fifo_pkg;

    localparam int AXI_ST_DATA_W = 128;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // DEPTH must be a power of two no smaller than 4; both margins lie in [1, DEPTH).
    function automatic bit params_ok(input int depth, input int af_margin, input int ae_margin);
        bit pow2;
        pow2 = (depth >= 4) && ((depth & (depth - 1)) == 0);
        return pow2 && (af_margin >= 1) && (af_margin < depth) &&
               (ae_margin >= 1) && (ae_margin < depth);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port memory with a synchronous write port and a registered,
// read-before-write read port that owns the FIFO output register.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_ST_DATA_W,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO core: pointers, occupancy counter, registered status flags
// and drop pulses around a dual-port memory.
module fifo_sync_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = AXI_ST_DATA_W,
    parameter int DEPTH      = 16,
    parameter int AF_MARGIN  = 2,
    parameter int AE_MARGIN  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      rd,
    output logic [DATA_WIDTH-1:0]     q,
    output logic                      full,
    output logic                      almost_full,
    output logic                      mty,
    output logic                      almost_mty,
    output logic [ptr_w(DEPTH):0]     count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (!params_ok(DEPTH, AF_MARGIN, AE_MARGIN)) begin : g_bad_params
        $error("fifo_sync_core: illegal DEPTH/AF_MARGIN/AE_MARGIN combination");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CNT_W-1:0] count_next;

    // A write into a full FIFO is still accepted when a read frees the head slot.
    assign wr_ok      = wr & (~full | rd);
    assign rd_ok      = rd & ~mty;
    assign count_next = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .q     (q)
    );

    // Flags are derived from count_next so they describe the post-edge occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            mty         <= 1'b1;
            almost_mty  <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count_next;
            full        <= (count_next == CNT_W'(DEPTH));
            almost_full <= (count_next >= CNT_W'(DEPTH - AF_MARGIN));
            mty         <= (count_next == '0);
            almost_mty  <= (count_next <= CNT_W'(AE_MARGIN));
            overflow    <= wr & ~wr_ok;
            underflow   <= rd & ~rd_ok;
        end
    end

endmodule

// File: tb/tb_fifo_sync_core.sv
// Randomised and directed bench for fifo_sync_core against a queue-based
// reference model of occupancy, data order and drop pulses.
module tb_fifo_sync_core;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int AEM   = 2;

    logic          clk;
    logic          rst_n;
    logic          wr;
    logic [DW-1:0] data;
    logic          rd;
    logic [DW-1:0] q;
    logic          full;
    logic          almost_full;
    logic          mty;
    logic          almost_mty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int check_count = 0;
    int error_count = 0;

    logic [DW-1:0] model_fifo [$];
    logic [DW-1:0] exp_q;
    logic          exp_ovf;
    logic          exp_unf;
    int            writes_done;

    fifo_sync_core #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (AFM),
        .AE_MARGIN  (AEM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .data        (data),
        .rd          (rd),
        .q           (q),
        .full        (full),
        .almost_full (almost_full),
        .mty         (mty),
        .almost_mty  (almost_mty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compareAll(input string tag);
        int n;
        n = model_fifo.size();
        checkOutput({tag, ".count"}, DW'(count), DW'(n));
        checkOutput({tag, ".full"}, DW'(full), DW'(n == DEPTH));
        checkOutput({tag, ".almost_full"}, DW'(almost_full), DW'(n >= DEPTH - AFM));
        checkOutput({tag, ".mty"}, DW'(mty), DW'(n == 0));
        checkOutput({tag, ".almost_mty"}, DW'(almost_mty), DW'(n <= AEM));
        checkOutput({tag, ".overflow"}, DW'(overflow), DW'(exp_ovf));
        checkOutput({tag, ".underflow"}, DW'(underflow), DW'(exp_unf));
        checkOutput({tag, ".q"}, q, exp_q);
    endtask

    // One clock of stimulus; the model then applies the acceptance rules to its pre-edge occupancy.
    task automatic applyStimulus(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
        bit w_acc;
        bit r_acc;
        wr   = w;
        data = d;
        rd   = r;
        @(posedge clk);
        #1;
        w_acc = w && (model_fifo.size() < DEPTH || r);
        r_acc = r && (model_fifo.size() > 0);
        if (r_acc) begin
            exp_q = model_fifo.pop_front();
        end
        if (w_acc) begin
            model_fifo.push_back(d);
            writes_done++;
        end
        exp_ovf = w && !w_acc;
        exp_unf = r && !r_acc;
        wr = 1'b0;
        rd = 1'b0;
        compareAll(tag);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic modelReset();
        model_fifo.delete();
        exp_q   = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    initial begin
        bit w;
        bit r;
        wr          = 1'b0;
        rd          = 1'b0;
        data        = '0;
        rst_n       = 1'b1;
        writes_done = 0;
        modelReset();

        // Reset and idle
        #1 rst_n = 1'b0;
        #2;
        compareAll("reset");
        #20 rst_n = 1'b1;
        applyStimulus("idle", 1'b0, '0, 1'b0);

        // Fill 0x1..0x10, then one write too many
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("fill", 1'b1, DW'(i), 1'b0);
        end
        applyStimulus("fill_ovf", 1'b1, DW'(32'hDEAD), 1'b0);
        checkOutput("fill_ovf_count", DW'(count), DW'(16));
        applyStimulus("ovf_clear", 1'b0, '0, 1'b0);

        // Drain, then one read too many
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("drain", 1'b0, '0, 1'b1);
        end
        applyStimulus("drain_unf", 1'b0, '0, 1'b1);
        checkOutput("drain_unf_q", q, DW'(16));

        // Full with simultaneous read and write
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("refill", 1'b1, DW'(i), 1'b0);
        end
        applyStimulus("full_rdwr", 1'b1, DW'(8'hAA), 1'b1);
        checkOutput("full_rdwr_q", q, DW'(1));
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("full_drain", 1'b0, '0, 1'b1);
        end
        checkOutput("full_last_q", q, DW'(8'hAA));

        // Empty with simultaneous read and write
        applyStimulus("empty_rdwr", 1'b1, DW'(8'h55), 1'b1);
        checkOutput("empty_rdwr_count", DW'(count), DW'(1));
        applyStimulus("empty_rd", 1'b0, '0, 1'b1);
        checkOutput("empty_rd_q", q, DW'(8'h55));

        // Mid-burst reset with no clock edge, then pointer wrap-around at occupancy 3..7
        applyStimulus("pre_rst", 1'b1, rand_word(), 1'b0);
        applyStimulus("pre_rst", 1'b1, rand_word(), 1'b0);
        wr = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        compareAll("mid_rst");
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus("wrap_prime", 1'b1, rand_word(), 1'b0);
        end
        writes_done = 0;
        for (int i = 0; i < 100; i++) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if (model_fifo.size() <= 3) r = 1'b0;
            if (model_fifo.size() >= 7) w = 1'b0;
            applyStimulus("wrap", w, rand_word(), r);
        end
        checkOutput("wrap_writes", DW'(writes_done >= 2 * DEPTH), DW'(1));

        while (model_fifo.size() > 0) begin
            applyStimulus("final_drain", 1'b0, '0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
